// File: rtl/register_file_hilo.sv
// Register file with 32 GPRs, HI/LO pair and a saturating commit counter.
// Reads are combinational with same-cycle bypass of the pending write.
`timescale 1ns/1ps
module register_file_hilo (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  input  logic [4:0]  WriteRegister,
  input  logic [31:0] WriteData,
  input  logic        RegWrite,
  input  logic        Move,
  input  logic        HiLoWrite,
  input  logic [31:0] HiWriteData,
  input  logic [31:0] LoWriteData,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic [31:0] ReadDataHi,
  output logic [31:0] ReadDataLo,
  output logic [15:0] WriteCount
);

  logic [31:0] gpr_q [32];
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [15:0] writeCount_q;
  logic [15:0] writeCount_d;
  logic        commit;

  assign commit = RegWrite && Move && (WriteRegister != 5'd0);

  // Counter sticks at all-ones instead of wrapping.
  always_comb begin
    writeCount_d = writeCount_q;
    if (commit && (writeCount_q != 16'hFFFF)) begin
      writeCount_d = writeCount_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < 32; i++) begin
        gpr_q[i] <= 32'd0;
      end
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      writeCount_q <= 16'd0;
    end else begin
      if (commit) begin
        gpr_q[WriteRegister] <= WriteData;
      end
      if (HiLoWrite) begin
        hi_q <= HiWriteData;
        lo_q <= LoWriteData;
      end
      writeCount_q <= writeCount_d;
    end
  end

  always_comb begin
    ReadData1 = gpr_q[ReadRegister1];
    if (ReadRegister1 == 5'd0) begin
      ReadData1 = 32'd0;
    end else if (commit && (ReadRegister1 == WriteRegister)) begin
      ReadData1 = WriteData;
    end
  end

  always_comb begin
    ReadData2 = gpr_q[ReadRegister2];
    if (ReadRegister2 == 5'd0) begin
      ReadData2 = 32'd0;
    end else if (commit && (ReadRegister2 == WriteRegister)) begin
      ReadData2 = WriteData;
    end
  end

  assign ReadDataHi = HiLoWrite ? HiWriteData : hi_q;
  assign ReadDataLo = HiLoWrite ? LoWriteData : lo_q;
  assign WriteCount = writeCount_q;

endmodule

// File: tb/tb_register_file_hilo.sv
// Self-checking bench: directed scenarios plus random traffic against an array-based model.
`timescale 1ns/1ps
module tb_register_file_hilo;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [4:0]  ReadRegister1 = '0;
  logic [4:0]  ReadRegister2 = '0;
  logic [4:0]  WriteRegister = '0;
  logic [31:0] WriteData = '0;
  logic        RegWrite = 1'b0;
  logic        Move = 1'b0;
  logic        HiLoWrite = 1'b0;
  logic [31:0] HiWriteData = '0;
  logic [31:0] LoWriteData = '0;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] ReadDataHi;
  logic [31:0] ReadDataLo;
  logic [15:0] WriteCount;

  logic [31:0] refGpr [32];
  logic [31:0] refHi;
  logic [31:0] refLo;
  int          refCount;
  int          assertCount = 0;
  int          failCount = 0;

  register_file_hilo dut (
    .Clk(Clk), .Rst(Rst),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .RegWrite(RegWrite), .Move(Move),
    .HiLoWrite(HiLoWrite), .HiWriteData(HiWriteData), .LoWriteData(LoWriteData),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .ReadDataHi(ReadDataHi), .ReadDataLo(ReadDataLo),
    .WriteCount(WriteCount)
  );

  always #5 Clk = ~Clk;

  function automatic void clearModel();
    for (int i = 0; i < 32; i++) refGpr[i] = 32'd0;
    refHi = 32'd0;
    refLo = 32'd0;
    refCount = 0;
  endfunction

  function automatic logic isCommit();
    return RegWrite && Move && (WriteRegister != 5'd0);
  endfunction

  function automatic logic [31:0] expRead(logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (isCommit() && idx == WriteRegister) return WriteData;
    return refGpr[idx];
  endfunction

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(string tag);
    checkOutput({tag, ".rd1"}, ReadData1, expRead(ReadRegister1));
    checkOutput({tag, ".rd2"}, ReadData2, expRead(ReadRegister2));
    checkOutput({tag, ".hi"}, ReadDataHi, HiLoWrite ? HiWriteData : refHi);
    checkOutput({tag, ".lo"}, ReadDataLo, HiLoWrite ? LoWriteData : refLo);
    checkOutput({tag, ".cnt"}, {16'd0, WriteCount}, refCount);
  endtask

  // Drive one cycle from a negedge, check the bypass view, then let the model take the edge.
  task automatic applyStimulus(string tag, logic rw, logic mv, logic [4:0] wr, logic [31:0] wd,
                               logic hl, logic [31:0] hd, logic [31:0] ld,
                               logic [4:0] r1, logic [4:0] r2);
    RegWrite = rw; Move = mv; WriteRegister = wr; WriteData = wd;
    HiLoWrite = hl; HiWriteData = hd; LoWriteData = ld;
    ReadRegister1 = r1; ReadRegister2 = r2;
    #1;
    checkAll(tag);
    @(posedge Clk);
    if (Rst) begin
      if (rw && mv && wr != 5'd0) begin
        refGpr[wr] = wd;
        if (refCount < 65535) refCount++;
      end
      if (hl) begin
        refHi = hd;
        refLo = ld;
      end
    end
    @(negedge Clk);
  endtask

  task automatic idleRead(logic [4:0] r1, logic [4:0] r2);
    RegWrite = 1'b0; Move = 1'b0; HiLoWrite = 1'b0;
    ReadRegister1 = r1; ReadRegister2 = r2;
    #1;
  endtask

  initial begin
    clearModel();
    ReadRegister1 = 5'd5;
    #2;
    checkOutput("resetRd1", ReadData1, 32'd0);
    checkOutput("resetHi", ReadDataHi, 32'd0);
    checkOutput("resetLo", ReadDataLo, 32'd0);
    checkOutput("resetCnt", {16'd0, WriteCount}, 32'd0);
    @(negedge Clk);
    Rst = 1'b1;

    applyStimulus("basicWr", 1, 1, 5'd8, 32'hDEADBEEF, 0, 0, 0, 5'd0, 5'd0);
    idleRead(5'd8, 5'd0);
    checkOutput("basicRead", ReadData1, 32'hDEADBEEF);
    checkOutput("basicCnt", {16'd0, WriteCount}, 32'd1);

    applyStimulus("blockedWr", 1, 0, 5'd9, 32'h12345678, 0, 0, 0, 5'd9, 5'd0);
    idleRead(5'd9, 5'd9);
    checkOutput("blockedRead", ReadData1, 32'd0);
    checkOutput("blockedCnt", {16'd0, WriteCount}, 32'd1);

    applyStimulus("reg0Wr", 1, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 5'd0, 5'd0);
    idleRead(5'd0, 5'd0);
    checkOutput("reg0Read", ReadData1, 32'd0);
    checkOutput("reg0Cnt", {16'd0, WriteCount}, 32'd1);

    RegWrite = 1'b1; Move = 1'b1; WriteRegister = 5'd5; WriteData = 32'hA5A5A5A5;
    ReadRegister2 = 5'd5;
    #1;
    checkOutput("bypassRd2", ReadData2, 32'hA5A5A5A5);
    applyStimulus("bypassWr", 1, 1, 5'd5, 32'hA5A5A5A5, 0, 0, 0, 5'd0, 5'd5);

    applyStimulus("hiloWr", 1, 1, 5'd31, 32'h400, 1, 32'h1, 32'h2, 5'd31, 5'd0);
    idleRead(5'd31, 5'd31);
    checkOutput("hiloHi", ReadDataHi, 32'h1);
    checkOutput("hiloLo", ReadDataLo, 32'h2);
    checkOutput("hiloGpr31", ReadData1, 32'h400);
    checkOutput("hiloCnt", {16'd0, WriteCount}, 32'd3);

    for (int i = 0; i < 300; i++) begin
      applyStimulus("rand", 1'($urandom), 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                    $urandom, 1'($urandom_range(0, 3) == 0), $urandom, $urandom,
                    5'($urandom_range(0, 7)), 5'($urandom));
    end
    idleRead(5'd3, 5'd6);
    checkAll("randEnd");

    // Saturation run: model steps per edge, checks only at the end.
    @(negedge Clk);
    RegWrite = 1'b1; Move = 1'b1; WriteRegister = 5'd1; WriteData = 32'h11110001; HiLoWrite = 1'b0;
    for (int i = 0; i < 65537; i++) begin
      @(posedge Clk);
      refGpr[1] = 32'h11110001;
      if (refCount < 65535) refCount++;
    end
    @(negedge Clk);
    idleRead(5'd1, 5'd0);
    checkOutput("satCnt", {16'd0, WriteCount}, 32'h0000FFFF);
    checkAll("satState");
    applyStimulus("satExtra", 1, 1, 5'd2, 32'h22220002, 0, 0, 0, 5'd2, 5'd1);
    idleRead(5'd2, 5'd1);
    checkOutput("satHold", {16'd0, WriteCount}, 32'h0000FFFF);
    checkAll("satHoldState");

    applyStimulus("preRst1", 1, 1, 5'd12, 32'h0BADF00D, 1, 32'h55, 32'h66, 5'd0, 5'd0);
    applyStimulus("preRst2", 1, 1, 5'd13, 32'h600DCAFE, 0, 0, 0, 5'd12, 5'd13);
    idleRead(5'd12, 5'd13);
    #1;
    Rst = 1'b0;
    #1;
    checkOutput("rstRd1", ReadData1, 32'd0);
    checkOutput("rstRd2", ReadData2, 32'd0);
    checkOutput("rstHi", ReadDataHi, 32'd0);
    checkOutput("rstLo", ReadDataLo, 32'd0);
    checkOutput("rstCnt", {16'd0, WriteCount}, 32'd0);
    clearModel();
    @(negedge Clk);
    applyStimulus("rstWr", 1, 1, 5'd12, 32'hCAFEF00D, 1, 32'h7, 32'h8, 5'd12, 5'd13);
    idleRead(5'd12, 5'd13);
    checkOutput("rstIgnGpr", ReadData1, 32'd0);
    checkOutput("rstIgnHi", ReadDataHi, 32'd0);
    checkOutput("rstIgnCnt", {16'd0, WriteCount}, 32'd0);

    #1;
    Rst = 1'b1;
    @(negedge Clk);
    applyStimulus("postRstWr", 1, 1, 5'd12, 32'h13572468, 1, 32'h9, 32'hA, 5'd0, 5'd0);
    idleRead(5'd12, 5'd13);
    checkOutput("postRstGpr", ReadData1, 32'h13572468);
    checkOutput("postRstCnt", {16'd0, WriteCount}, 32'd1);
    checkAll("postRstState");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/register_file_hilo.md
REGISTER_FILE_HILO -- requirements
Module: register_file_hilo

Interface
REQ-001 The block SHALL have the port Clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port Rst, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have the ports ReadRegister1 and ReadRegister2, input, 5 bits each: source register indices for read ports 1 and 2.
REQ-004 The block SHALL have the port WriteRegister, input, 5 bits: destination index, driven by the writeback stage's WriteAddressOut.
REQ-005 The block SHALL have the port WriteData, input, 32 bits: the writeback result.
REQ-006 The block SHALL have the port RegWrite, input, 1 bit: the pipeline's write-enable control.
REQ-007 The block SHALL have the port Move, input, 1 bit: the writeback conditional-move qualifier; 1 means the write is permitted.
REQ-008 The block SHALL have the port HiLoWrite, input, 1 bit: writes both HI and LO.
REQ-009 The block SHALL have the ports HiWriteData and LoWriteData, input, 32 bits each: the new HI and LO values.
REQ-010 The block SHALL have the ports ReadData1 and ReadData2, output, 32 bits each: the read port results.
REQ-011 The block SHALL have the ports ReadDataHi and ReadDataLo, output, 32 bits each: the current HI and LO values, fed back to the writeback stage.
REQ-012 The block SHALL have the port WriteCount, output, 16 bits: a saturating count of committed GPR writes.

Function
REQ-013 The block SHALL hold 32 x 32-bit general-purpose registers (GPRs) plus one 32-bit HI register and one 32-bit LO register.
REQ-014 The block SHALL define commit = RegWrite AND Move AND (WriteRegister != 0).
REQ-015 On a rising edge of Clk with commit=1, the block SHALL set GPR[WriteRegister] to WriteData.
REQ-016 When commit=0, the block SHALL leave every GPR unchanged.
REQ-017 GPR 0 SHALL never be written and SHALL always read as 0x00000000.
REQ-018 ReadDataN (N = 1, 2) SHALL be combinational, with the following priority:
- ReadRegisterN = 0: output 0.
- Otherwise, commit=1 and ReadRegisterN = WriteRegister: output WriteData (same-cycle bypass).
- Otherwise: output GPR[ReadRegisterN].
REQ-019 Both read ports SHALL operate independently, and SHALL return identical data when they carry the same index.
REQ-020 On a rising edge of Clk with HiLoWrite=1, the block SHALL load HI from HiWriteData and LO from LoWriteData in the same edge.
REQ-021 ReadDataHi and ReadDataLo SHALL bypass: while HiLoWrite=1 they SHALL output HiWriteData and LoWriteData; otherwise they SHALL output the stored HI and LO.
REQ-022 A HI/LO write and a GPR commit in the same cycle SHALL both take effect; neither SHALL block the other.
REQ-023 WriteCount SHALL increment by 1 on each rising edge of Clk with commit=1.
REQ-024 WriteCount SHALL saturate at 0xFFFF and hold there; it SHALL NOT wrap to 0.
REQ-025 Attempted writes with Move=0, RegWrite=0, or WriteRegister=0 SHALL NOT increment WriteCount.
REQ-026 Read latency SHALL be 0 cycles (combinational); write latency SHALL be 1 edge, with the written value visible in the same cycle through the bypass.

Reset
REQ-027 While Rst=0, the block SHALL clear all GPRs, HI, LO and WriteCount to 0 immediately, without waiting for a clock edge.
REQ-028 While Rst=0, the block SHALL ignore all writes, including a rising edge of Clk that coincides with commit=1 or HiLoWrite=1.
REQ-029 While Rst=0, the outputs SHALL read 0, except the combinational bypass values defined in REQ-018 and REQ-021.
REQ-030 When Rst returns to 1 between clock edges, the first write SHALL occur on the next rising edge of Clk with commit=1 or HiLoWrite=1.

Verification
REQ-031 The bench SHALL cover a basic write and read:
- Stimulus: RegWrite=1, Move=1, WriteRegister=8, WriteData=0xDEADBEEF for one edge, then ReadRegister1=8.
- Required response: ReadData1=0xDEADBEEF and WriteCount=1.
REQ-032 The bench SHALL cover a blocked conditional move:
- Stimulus: RegWrite=1, Move=0, WriteRegister=9, WriteData=0x12345678 for one edge, then read register 9.
- Required response: ReadData=0 and WriteCount unchanged.
REQ-033 The bench SHALL cover register 0 and the same-cycle bypass:
- Stimulus A: commit attempted to register 0 with 0xFFFFFFFF. Required response: ReadData1 for index 0 = 0 and WriteCount unchanged.
- Stimulus B: in the same cycle as a write of 0xA5A5A5A5 to register 5, ReadRegister2=5. Required response: ReadData2=0xA5A5A5A5 before the edge.
REQ-034 The bench SHALL cover a simultaneous GPR and HI/LO write:
- Stimulus: HiLoWrite=1, HiWriteData=0x1, LoWriteData=0x2, together with a commit to register 31 of 0x400.
- Required response: after the edge, ReadDataHi=1, ReadDataLo=2, GPR31=0x400.
REQ-035 The bench SHALL cover counter saturation:
- Stimulus: 65537 consecutive commits.
- Required response: WriteCount=0xFFFF, with no wrap to 0.
REQ-036 The bench SHALL cover reset mid-operation:
- Stimulus: after several writes, drive Rst=0 between clock edges.
- Required response: all reads, HI, LO and WriteCount are 0 immediately; a commit on the next edge while Rst=0 is ignored.
